// File: rtl/lcd_pkg.sv
`default_nettype none
// lcd_pkg: HD44780 command bytes and the helpers that turn a 32-bit value into hex characters.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] ROW0     = 8'h80;
  localparam logic [7:0] ROW1     = 8'hC0;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return FUNC_SET;
      2'd1:    return DISP_ON;
      2'd2:    return CLEAR;
      default: return ENTRY;
    endcase
  endfunction

  // Uppercase ASCII: 0x37 + n lands on 'A' for n = 10.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character k of a row is the k-th nibble counted from the most significant end.
  function automatic logic [3:0] nibble_at(input logic [31:0] v, input logic [2:0] k);
    logic [31:0] s;
    s = v >> (5'd28 - {k, 2'b00});
    return s[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_writer.sv
`default_nettype none
// lcd_bus_writer: one HD44780 byte write (setup, enable strobe, post-wait), then a done pulse.
// Revision: 1.0
module lcd_bus_writer #(
  parameter int EN_CYC = 50,
  parameter int CW     = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    byte_val,
  input  logic          rs,
  input  logic [CW-1:0] wait_cyc,
  output logic [7:0]    lcd_data,
  output logic          lcd_rs,
  output logic          lcd_en,
  output logic          done
);

  typedef enum logic [1:0] {W_IDLE, W_SETUP, W_EN, W_POST} wstate_t;

  wstate_t       state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] post_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= W_IDLE;
      cnt      <= '0;
      post_len <= '0;
      lcd_data <= '0;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        W_IDLE: begin
          if (start) begin
            lcd_data <= byte_val;
            lcd_rs   <= rs;
            post_len <= wait_cyc;
            state    <= W_SETUP;
          end
        end
        W_SETUP: begin
          lcd_en <= 1'b1;
          cnt    <= '0;
          state  <= W_EN;
        end
        W_EN: begin
          if (cnt == CW'(EN_CYC - 1)) begin
            lcd_en <= 1'b0;
            cnt    <= '0;
            state  <= W_POST;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        W_POST: begin
          // lcd_data/lcd_rs are left untouched so they stay valid through the whole wait.
          if (cnt + CW'(1) >= post_len) begin
            done  <= 1'b1;
            cnt   <= '0;
            state <= W_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_hex_driver.sv
`default_nettype none
// lcd_hex_driver: initialises an HD44780 LCD and continuously shows line1/line2 as 8 hex digits each.
// Revision: 1.0
module lcd_hex_driver
  import lcd_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int PWR_CYC = 750_000,
  parameter int EN_CYC  = 50,
  parameter int CMD_CYC = 2_500,
  parameter int CLR_CYC = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] line1,
  input  logic [31:0] line2,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        init_done,
  output logic        frame_done
);

  localparam int MAX_A = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
  localparam int MAX_B = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
  localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXC + 1);

  if (CLK_HZ < 1) begin : g_bad_clk
    $error("CLK_HZ must be positive");
  end

  typedef enum logic [2:0] {S_PWR_WAIT, S_INIT, S_ADDR0, S_ROW0, S_ADDR1, S_ROW1} state_t;

  state_t        state;
  logic [CW-1:0] pwr_cnt;
  logic [1:0]    init_idx;
  logic [2:0]    char_idx;
  logic          busy;
  logic [31:0]   snap1, snap2;
  logic          start;
  logic [7:0]    tx_byte;
  logic          tx_rs;
  logic [CW-1:0] tx_wait;
  logic          wr_done;

  logic [7:0]    nxt_byte;
  logic          nxt_rs;
  logic [CW-1:0] nxt_wait;

  assign lcd_rw = 1'b0;

  always_comb begin
    nxt_byte = init_cmd(init_idx);
    nxt_rs   = 1'b0;
    nxt_wait = CW'(CMD_CYC);
    case (state)
      S_INIT:  if (init_idx == 2'd2) nxt_wait = CW'(CLR_CYC);
      S_ADDR0: nxt_byte = ROW0;
      S_ROW0: begin
        nxt_byte = hex_ascii(nibble_at(snap1, char_idx));
        nxt_rs   = 1'b1;
      end
      S_ADDR1: nxt_byte = ROW1;
      S_ROW1: begin
        nxt_byte = hex_ascii(nibble_at(snap2, char_idx));
        nxt_rs   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_PWR_WAIT;
      pwr_cnt    <= '0;
      init_idx   <= '0;
      char_idx   <= '0;
      busy       <= 1'b0;
      snap1      <= '0;
      snap2      <= '0;
      start      <= 1'b0;
      tx_byte    <= '0;
      tx_rs      <= 1'b0;
      tx_wait    <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      start      <= 1'b0;
      frame_done <= 1'b0;
      if (state == S_PWR_WAIT) begin
        if (pwr_cnt == CW'(PWR_CYC - 1)) begin
          pwr_cnt <= '0;
          state   <= S_INIT;
        end else begin
          pwr_cnt <= pwr_cnt + CW'(1);
        end
      end else if (!busy) begin
        start   <= 1'b1;
        busy    <= 1'b1;
        tx_byte <= nxt_byte;
        tx_rs   <= nxt_rs;
        tx_wait <= nxt_wait;
      end else if (wr_done) begin
        busy <= 1'b0;
        case (state)
          S_INIT: begin
            if (init_idx == 2'd3) begin
              init_done <= 1'b1;
              snap1     <= line1;
              snap2     <= line2;
              state     <= S_ADDR0;
            end
            init_idx <= init_idx + 2'd1;
          end
          S_ADDR0: begin
            char_idx <= '0;
            state    <= S_ROW0;
          end
          S_ROW0: begin
            if (char_idx == 3'd7) state <= S_ADDR1;
            char_idx <= char_idx + 3'd1;
          end
          S_ADDR1: state <= S_ROW1;
          S_ROW1: begin
            // Snapshot on every entry to ADDR0 so a frame never mixes old and new inputs.
            if (char_idx == 3'd7) begin
              frame_done <= 1'b1;
              snap1      <= line1;
              snap2      <= line2;
              state      <= S_ADDR0;
            end
            char_idx <= char_idx + 3'd1;
          end
          default: state <= S_PWR_WAIT;
        endcase
      end
    end
  end

  lcd_bus_writer #(
    .EN_CYC (EN_CYC),
    .CW     (CW)
  ) u_writer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .byte_val (tx_byte),
    .rs       (tx_rs),
    .wait_cyc (tx_wait),
    .lcd_data (lcd_data),
    .lcd_rs   (lcd_rs),
    .lcd_en   (lcd_en),
    .done     (wr_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_lcd_hex_driver.sv
`default_nettype none
// tb_lcd_hex_driver: directed check of the LCD init/refresh byte stream, strobe timing and reset.
module tb_lcd_hex_driver;

  localparam int PWR = 20;
  localparam int EN  = 3;
  localparam int CMD = 10;
  localparam int CLR = 40;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] line1 = '0;
  logic [31:0] line2 = '0;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, init_done, frame_done;

  lcd_hex_driver #(
    .CLK_HZ  (50_000_000),
    .PWR_CYC (PWR),
    .EN_CYC  (EN),
    .CMD_CYC (CMD),
    .CLR_CYC (CLR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line1      (line1),
    .line2      (line2),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .init_done  (init_done),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic rs; int gap; } cap_t;
  typedef struct { logic [7:0] data; logic rs; int min_gap; } vec_t;

  cap_t cap_q[$];
  vec_t tbl[40];
  int   k        = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   fd_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic rs, input int g);
    tbl[k] = '{d, rs, g};
    k++;
  endtask

  task automatic get_byte(output cap_t c, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    c  = '{8'h00, 1'b0, 0};
    while (cap_q.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (cap_q.size() > 0) begin
      c  = cap_q.pop_front();
      ok = 1'b1;
    end else begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: no lcd_en pulse within %0d clocks", n);
    end
  endtask

  task automatic check_vec(input string tag, input int i, input cap_t c);
    chk({tag, "_data"}, {24'd0, c.data}, {24'd0, tbl[i].data});
    chk({tag, "_rs"}, {31'd0, c.rs}, {31'd0, tbl[i].rs});
    checks++;
    if (c.gap < tbl[i].min_gap) begin
      errors++;
      $display("FAIL %s_gap: idle gap %0d clocks, want >= %0d", tag, c.gap, tbl[i].min_gap);
    end
  endtask

  // Bus monitor: records every enable pulse and checks its width and data stability.
  initial begin : monitor
    logic       pen;
    logic [7:0] pd;
    logic       prs;
    int         hi, gap, fdl;
    pen = 1'b0; pd = '0; prs = 1'b0; hi = 0; gap = 0; fdl = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pen = 1'b0; hi = 0; gap = 0; fdl = 0;
      end else begin
        if (lcd_en) begin
          if (!pen) begin
            cap_q.push_back('{lcd_data, lcd_rs, gap});
            hi = 0;
          end
          hi++;
          chk("stable_setup_en", {23'd0, lcd_rs, lcd_data}, {23'd0, prs, pd});
        end else begin
          if (pen) begin
            chk("en_width", hi, EN);
            gap = 0;
          end
          gap++;
          if (gap <= CMD)
            chk("stable_post", {23'd0, lcd_rs, lcd_data}, {23'd0, prs, pd});
        end
        if (frame_done) fdl++;
        else if (fdl > 0) begin
          chk("frame_done_width", fdl, 1);
          fd_count++;
          fdl = 0;
        end
      end
      pen = lcd_en; pd = lcd_data; prs = lcd_rs;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    cap_t       c;
    bit         ok;
    int         n;
    logic [7:0] r2 [8];
    r2 = '{8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};

    add(8'h38, 1'b0, PWR);
    add(8'h0C, 1'b0, CMD);
    add(8'h01, 1'b0, CMD);
    add(8'h06, 1'b0, CLR);
    for (int f = 0; f < 2; f++) begin
      add(8'h80, 1'b0, CMD);
      for (int j = 0; j < 8; j++) add((f == 0) ? 8'h30 + 8'(j) : 8'h46, 1'b1, CMD);
      add(8'hC0, 1'b0, CMD);
      for (int j = 0; j < 8; j++) add(r2[j], 1'b1, CMD);
    end

    line1 = 32'h0123_4567;
    line2 = 32'h89AB_CDEF;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_en", {31'd0, lcd_en}, 32'd0);
    chk("rst_data", {24'd0, lcd_data}, 32'd0);
    chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;

    // Init, frame 1 with line1 changed mid-row, then frame 2 showing the new value.
    for (int i = 0; i < 40; i++) begin
      get_byte(c, ok);
      if (!ok) break;
      check_vec($sformatf("v%0d", i), i, c);
      if (i == 3) chk("init_done_during_0x06", {31'd0, init_done}, 32'd0);
      if (i == 4) begin
        chk("init_done_after_init", {31'd0, init_done}, 32'd1);
        chk("no_frame_done_yet", fd_count, 0);
      end
      if (i == 8) line1 = 32'hFFFF_FFFF;
      if (i == 22) chk("frame_done_count", fd_count, 1);
    end
    chk("rw_low_run", {31'd0, lcd_rw}, 32'd0);

    // Reset while the enable strobe is high during row 1 of frame 3.
    n = 0;
    do begin
      get_byte(c, ok);
      n++;
    end while (ok && c.data != 8'hC0 && n < 20);
    get_byte(c, ok);
    n = 0;
    while (!lcd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("en_high_before_reset", {31'd0, lcd_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_en", {31'd0, lcd_en}, 32'd0);
    chk("midrst_data", {24'd0, lcd_data}, 32'd0);
    chk("midrst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("midrst_rw", {31'd0, lcd_rw}, 32'd0);
    chk("midrst_init_done", {31'd0, init_done}, 32'd0);
    repeat (3) @(negedge clk);
    cap_q.delete();
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      get_byte(c, ok);
      if (!ok) break;
      check_vec($sformatf("re%0d", i), i, c);
      if (i == 3) chk("re_init_done_during_0x06", {31'd0, init_done}, 32'd0);
      if (i == 4) chk("re_init_done_after_init", {31'd0, init_done}, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
